// File: rtl/disarm_session_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// disarm_pkg
// Shared definitions for the alarm-disarm session controller:
//   - state_t   : session sequencer states
//   - OP_*      : arithmetic operation codes shared with the problem generator
//   - problem_t : one latched problem (operands, op, expected answer)
//   - FB_*      : fallback problem used when the generator does not respond
// -----------------------------------------------------------------------------
package disarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_GEN = 3'd2,
        ST_PRESENT  = 3'd3,
        ST_JUDGE    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef struct packed {
        logic [7:0] num1;
        logic [7:0] num2;
        logic [2:0] op;
        logic [7:0] answer;
    } problem_t;

    localparam logic [7:0] FB_NUM1 = 8'd23;
    localparam logic [7:0] FB_NUM2 = 8'd17;
    localparam logic [2:0] FB_OP   = OP_SUB;
    localparam logic [7:0] FB_ANS  = 8'd6;

    function automatic problem_t fallback_problem();
        problem_t p;
        p.num1   = FB_NUM1;
        p.num2   = FB_NUM2;
        p.op     = FB_OP;
        p.answer = FB_ANS;
        return p;
    endfunction

endpackage

// File: rtl/disarm_session_ctrl_if.sv
// -----------------------------------------------------------------------------
// disarm_session_ctrl_if
// Bundles every non-clock/reset signal of the disarm session controller.
//   slave  : the controller (consumes trigger/tick/keypad/generator inputs,
//            drives generator request, buzzer, display and result pulses)
//   master : the environment (generator, keypad, 1 Hz source, display)
// -----------------------------------------------------------------------------
interface disarm_session_ctrl_if;

    // environment -> controller
    logic       alarm_trigger;
    logic       tick_1hz;
    logic       ans_valid;
    logic [7:0] ans_value;
    logic       gen_ready;
    logic [7:0] gen_answer;
    logic [7:0] gen_num1;
    logic [7:0] gen_num2;
    logic [2:0] gen_op;

    // controller -> environment
    logic       gen_req;
    logic       alarm_on;
    logic       prob_valid;
    logic [7:0] disp_num1;
    logic [7:0] disp_num2;
    logic [2:0] disp_op;
    logic [7:0] time_left;
    logic [3:0] streak;
    logic       result_ok;
    logic       result_bad;
    logic       disarmed;

    modport slave (
        input  alarm_trigger, tick_1hz, ans_valid, ans_value,
               gen_ready, gen_answer, gen_num1, gen_num2, gen_op,
        output gen_req, alarm_on, prob_valid, disp_num1, disp_num2, disp_op,
               time_left, streak, result_ok, result_bad, disarmed
    );

    modport master (
        output alarm_trigger, tick_1hz, ans_valid, ans_value,
               gen_ready, gen_answer, gen_num1, gen_num2, gen_op,
        input  gen_req, alarm_on, prob_valid, disp_num1, disp_num2, disp_op,
               time_left, streak, result_ok, result_bad, disarmed
    );

endinterface

// File: rtl/disarm_session_ctrl_timer.sv
// -----------------------------------------------------------------------------
// problem_timer
// Per-problem countdown in seconds.
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : load TIME_LIMIT (problem becomes live)
//   i_run        : countdown enabled (problem live and not being answered)
//   i_tick       : 1 Hz strobe
//   o_time_left  : seconds remaining, saturates at 0
//   o_expired    : single-cycle pulse on the tick that takes 1 -> 0
// -----------------------------------------------------------------------------
module problem_timer #(
    parameter int TIME_LIMIT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_run,
    input  logic       i_tick,
    output logic [7:0] o_time_left,
    output logic       o_expired
);

    logic [7:0] r_time_left;

    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time_left <= 8'd0;
        end else if (i_load) begin
            r_time_left <= 8'(TIME_LIMIT);
        end else if (i_run && i_tick && (r_time_left != 8'd0)) begin
            r_time_left <= r_time_left - 8'd1;
        end
    end

    // Combinational so the sequencer can act on the very tick that empties
    // the counter; the sequencer registers the consequence.
    assign o_expired   = i_run && i_tick && (r_time_left == 8'd1);
    assign o_time_left = r_time_left;

endmodule

// File: rtl/disarm_session_ctrl.sv
// -----------------------------------------------------------------------------
// disarm_session_ctrl
// Sequencer for one alarm-disarm session: fetch a problem from the generator
// (or fall back to 23 - 17 after GEN_WAIT_MAX cycles), show it, judge the
// keypad answer, and silence the alarm after REQ_CORRECT consecutive correct
// answers. A per-problem timeout counts as a wrong answer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : disarm_session_ctrl_if.slave (trigger, tick, keypad, generator
//              inputs; gen_req, alarm_on, display, result pulses outputs)
// All outputs are registered.
// -----------------------------------------------------------------------------
module disarm_session_ctrl
    import disarm_pkg::*;
#(
    parameter int REQ_CORRECT  = 3,
    parameter int TIME_LIMIT   = 30,
    parameter int GEN_WAIT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    disarm_session_ctrl_if.slave  bus
);

    localparam int WAIT_W = $clog2(GEN_WAIT_MAX + 1);

    state_t             r_state;
    logic               r_gen_ready_q;
    logic [WAIT_W-1:0]  r_wait_cnt;
    problem_t           r_prob;
    logic [7:0]         r_ans;
    logic [3:0]         r_streak;
    logic               r_gen_req;
    logic               r_alarm_on;
    logic               r_prob_valid;
    logic               r_result_ok;
    logic               r_result_bad;
    logic               r_disarmed;

    logic               w_ready_rise;
    logic               w_wait_done;
    logic               w_timer_load;
    logic               w_timer_run;
    logic [7:0]         w_time_left;
    logic               w_expired;

    // Only a fresh edge counts; a level left high from before is ignored.
    assign w_ready_rise = bus.gen_ready && !r_gen_ready_q;
    // The counter starts at 0 on the first WAIT_GEN cycle, so hitting
    // GEN_WAIT_MAX-1 means GEN_WAIT_MAX cycles have been spent waiting.
    assign w_wait_done  = (r_wait_cnt == WAIT_W'(GEN_WAIT_MAX - 1));

    assign w_timer_load = (r_state == ST_WAIT_GEN) && (w_ready_rise || w_wait_done);
    // An answer in the same cycle as the final tick wins: freeze the count.
    assign w_timer_run  = (r_state == ST_PRESENT) && !bus.ans_valid;

    problem_timer #(
        .TIME_LIMIT (TIME_LIMIT)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_timer_load),
        .i_run       (w_timer_run),
        .i_tick      (bus.tick_1hz),
        .o_time_left (w_time_left),
        .o_expired   (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gen_ready_q <= 1'b0;
        end else begin
            r_gen_ready_q <= bus.gen_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_prob       <= '0;
            r_ans        <= 8'd0;
            r_streak     <= 4'd0;
            r_gen_req    <= 1'b0;
            r_alarm_on   <= 1'b0;
            r_prob_valid <= 1'b0;
            r_result_ok  <= 1'b0;
            r_result_bad <= 1'b0;
            r_disarmed   <= 1'b0;
        end else begin
            // Pulse outputs default low; states below raise them for one cycle.
            r_result_ok  <= 1'b0;
            r_result_bad <= 1'b0;
            r_disarmed   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.alarm_trigger) begin
                        r_state    <= ST_FETCH;
                        r_alarm_on <= 1'b1;
                        r_gen_req  <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT_GEN;
                end

                ST_WAIT_GEN: begin
                    if (w_ready_rise) begin
                        r_prob       <= '{num1:   bus.gen_num1,
                                          num2:   bus.gen_num2,
                                          op:     bus.gen_op,
                                          answer: bus.gen_answer};
                        r_state      <= ST_PRESENT;
                        r_gen_req    <= 1'b0;
                        r_prob_valid <= 1'b1;
                    end else if (w_wait_done) begin
                        r_prob       <= fallback_problem();
                        r_state      <= ST_PRESENT;
                        r_gen_req    <= 1'b0;
                        r_prob_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end

                ST_PRESENT: begin
                    if (bus.ans_valid) begin
                        r_ans        <= bus.ans_value;
                        r_state      <= ST_JUDGE;
                        r_prob_valid <= 1'b0;
                    end else if (w_expired) begin
                        r_result_bad <= 1'b1;
                        r_streak     <= 4'd0;
                        r_state      <= ST_FETCH;
                        r_gen_req    <= 1'b1;
                        r_prob_valid <= 1'b0;
                    end
                end

                ST_JUDGE: begin
                    if (r_ans == r_prob.answer) begin
                        r_result_ok <= 1'b1;
                        r_streak    <= r_streak + 4'd1;
                        if ((r_streak + 4'd1) == 4'(REQ_CORRECT)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state   <= ST_FETCH;
                            r_gen_req <= 1'b1;
                        end
                    end else begin
                        r_result_bad <= 1'b1;
                        r_streak     <= 4'd0;
                        r_state      <= ST_FETCH;
                        r_gen_req    <= 1'b1;
                    end
                end

                ST_DONE: begin
                    r_disarmed <= 1'b1;
                    r_alarm_on <= 1'b0;
                    r_streak   <= 4'd0;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gen_req    = r_gen_req;
    assign bus.alarm_on   = r_alarm_on;
    assign bus.prob_valid = r_prob_valid;
    assign bus.disp_num1  = r_prob.num1;
    assign bus.disp_num2  = r_prob.num2;
    assign bus.disp_op    = r_prob.op;
    assign bus.time_left  = w_time_left;
    assign bus.streak     = r_streak;
    assign bus.result_ok  = r_result_ok;
    assign bus.result_bad = r_result_bad;
    assign bus.disarmed   = r_disarmed;

endmodule

// File: tb/tb_disarm_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disarm_session_ctrl
// Self-checking bench: the bench plays generator, keypad and 1 Hz source.
// Expected values come from a session-level model (arithmetic answer per op,
// a consecutive-correct count, a seconds countdown), not from the DUT.
// -----------------------------------------------------------------------------
module tb_disarm_session_ctrl;

    localparam int REQ = 3;
    localparam int TL  = 3;
    localparam int GW  = 255;

    logic clk = 1'b0;
    logic rst;

    disarm_session_ctrl_if bus ();

    disarm_session_ctrl #(
        .REQ_CORRECT  (REQ),
        .TIME_LIMIT   (TL),
        .GEN_WAIT_MAX (GW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // session model
    int model_streak   = 0;
    int model_tl       = 0;
    bit model_disarmed = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance n clock edges and settle 1 time unit after the last one.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] calc(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return 8'((16'(a) * 16'(b)) & 16'hff);
            3'd3:    return a / b;
            default: return a % b;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {bus.gen_req, bus.alarm_on, bus.prob_valid,
                               bus.result_ok, bus.result_bad, bus.disarmed}, 0);
        check({tag, "_disp"}, {bus.disp_num1, bus.disp_num2, bus.disp_op}, 0);
        check({tag, "_cnt"},  {bus.time_left, bus.streak}, 0);
    endtask

    task automatic trigger();
        bus.alarm_trigger = 1'b1;
        step();
        bus.alarm_trigger = 1'b0;
        check("trig_gen_req", bus.gen_req, 1);
        check("trig_alarm",   bus.alarm_on, 1);
    endtask

    // Generator delivers a problem with a fresh gen_ready edge.
    task automatic present(input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, output logic [7:0] ans);
        ans = calc(a, b, op);
        step(1 + $urandom_range(0, 3));
        check("pre_gen_req", bus.gen_req, 1);
        bus.gen_num1   = a;
        bus.gen_num2   = b;
        bus.gen_op     = op;
        bus.gen_answer = ans;
        bus.gen_ready  = 1'b1;
        step();
        bus.gen_ready  = 1'b0;
        bus.gen_num1   = 8'($urandom);
        bus.gen_num2   = 8'($urandom);
        bus.gen_op     = 3'($urandom);
        bus.gen_answer = 8'($urandom);
        model_tl = TL;
        check("pv_up",     bus.prob_valid, 1);
        check("disp_num1", bus.disp_num1, a);
        check("disp_num2", bus.disp_num2, b);
        check("disp_op",   bus.disp_op, op);
        check("tl_load",   bus.time_left, TL);
        check("req_drop",  bus.gen_req, 0);
    endtask

    task automatic present_random(output logic [7:0] ans);
        logic [7:0] a, b;
        logic [2:0] op;
        a  = 8'($urandom);
        b  = 8'($urandom_range(1, 255));
        op = 3'($urandom_range(0, 4));
        present(a, b, op, ans);
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) step(gap);
            bus.tick_1hz = 1'b1;
            step();
            bus.tick_1hz = 1'b0;
            model_tl--;
            check("tl_tick", bus.time_left, model_tl);
        end
    endtask

    // Check what follows a judged result: disarm, or back to fetching.
    task automatic finish_problem();
        model_disarmed = 1'b0;
        if (model_streak == REQ) begin
            step();
            check("disarmed",     bus.disarmed, 1);
            check("alarm_off",    bus.alarm_on, 0);
            check("streak_clr",   bus.streak, 0);
            model_streak   = 0;
            model_disarmed = 1'b1;
            step();
            check("disarm_pulse", bus.disarmed, 0);
            check("idle_req",     bus.gen_req, 0);
        end else begin
            step();
            check("next_req",   bus.gen_req, 1);
            check("alarm_hold", bus.alarm_on, 1);
        end
    endtask

    task automatic answer(input logic [7:0] val, input logic [7:0] correct);
        bit ok;
        ok = (val == correct);
        bus.ans_valid = 1'b1;
        bus.ans_value = val;
        step();
        bus.ans_valid = 1'b0;
        bus.ans_value = 8'($urandom);
        check("res_early", {bus.result_ok, bus.result_bad}, 0);
        step();
        if (ok) model_streak++;
        else    model_streak = 0;
        check("result_ok",  bus.result_ok, 32'(ok));
        check("result_bad", bus.result_bad, 32'(!ok));
        check("streak",     bus.streak, model_streak);
        finish_problem();
    endtask

    task automatic timeout();
        ticks(TL - 1);
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        model_streak = 0;
        check("to_tl0",  bus.time_left, 0);
        check("to_bad",  bus.result_bad, 1);
        check("to_ok",   bus.result_ok, 0);
        check("to_strk", bus.streak, 0);
        step();
        check("to_pulse", bus.result_bad, 0);
        check("to_req",   bus.gen_req, 1);
        check("to_alarm", bus.alarm_on, 1);
    endtask

    task automatic simultaneous(input logic [7:0] correct);
        ticks(TL - 1);
        bus.tick_1hz  = 1'b1;
        bus.ans_valid = 1'b1;
        bus.ans_value = correct;
        step();
        bus.tick_1hz  = 1'b0;
        bus.ans_valid = 1'b0;
        check("sim_no_bad0", bus.result_bad, 0);
        step();
        model_streak++;
        check("sim_ok",     bus.result_ok, 1);
        check("sim_no_bad", bus.result_bad, 0);
        check("sim_streak", bus.streak, model_streak);
        finish_problem();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] ans;
        int         cnt;

        rst               = 1'b1;
        bus.alarm_trigger = 1'b0;
        bus.tick_1hz      = 1'b0;
        bus.ans_valid     = 1'b0;
        bus.ans_value     = 8'd0;
        bus.gen_ready     = 1'b0;
        bus.gen_answer    = 8'd0;
        bus.gen_num1      = 8'd0;
        bus.gen_num2      = 8'd0;
        bus.gen_op        = 3'd0;
        step(2);
        check_all_zero("reset");
        rst = 1'b0;
        step(2);
        check("idle_alarm", bus.alarm_on, 0);

        // Session A: three correct answers -> disarm
        trigger();
        present(8'd100, 8'd50, 3'd0, ans);
        check("model_add", ans, 150);
        answer(ans, ans);
        present(8'd7, 8'd9, 3'd2, ans);
        check("model_mul", ans, 63);
        answer(ans, ans);
        present(8'd96, 8'd12, 3'd3, ans);
        check("model_div", ans, 8);
        answer(ans, ans);
        check("sessA_done", 32'(model_disarmed), 1);

        // Session B: ignored trigger/answer, wrong answer, timeout,
        // simultaneous answer+tick, fallback problem
        trigger();
        step();
        bus.alarm_trigger = 1'b1;
        step();
        bus.alarm_trigger = 1'b0;
        check("retrig_req",   bus.gen_req, 1);
        check("retrig_alarm", bus.alarm_on, 1);
        check("retrig_pv",    bus.prob_valid, 0);
        bus.ans_valid = 1'b1;
        bus.ans_value = 8'($urandom);
        step();
        bus.ans_valid = 1'b0;
        step(2);
        check("stray_ans", {bus.result_ok, bus.result_bad}, 0);
        present_random(ans);
        answer(ans, ans);
        present_random(ans);
        answer(ans, ans);
        present(8'd67, 8'd3, 3'd2, ans);
        answer(8'd200, ans);
        present_random(ans);
        timeout();
        present_random(ans);
        simultaneous(ans);
        cnt = 0;
        while (!bus.prob_valid && cnt < GW + 10) begin
            step();
            cnt++;
        end
        check("fb_arrive", bus.prob_valid, 1);
        check("fb_window", 32'((cnt >= GW - 2) && (cnt <= GW + 3)), 1);
        check("fb_num1",   bus.disp_num1, 23);
        check("fb_num2",   bus.disp_num2, 17);
        check("fb_op",     bus.disp_op, 1);
        model_tl = TL;
        answer(8'd6, 8'd6);
        present_random(ans);
        answer(ans, ans);
        check("sessB_done", 32'(model_disarmed), 1);

        // Session C: reset in PRESENT with streak 2
        trigger();
        present_random(ans);
        answer(ans, ans);
        present_random(ans);
        answer(ans, ans);
        check("pre_rst_streak", bus.streak, 2);
        present_random(ans);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_streak = 0;
        step();
        rst = 1'b0;
        step(2);
        check("post_rst_idle", {bus.alarm_on, bus.gen_req}, 0);

        // Random sessions
        for (int s = 0; s < 6; s++) begin
            int nprob;
            nprob = 0;
            trigger();
            model_disarmed = 1'b0;
            while (!model_disarmed && nprob < 30) begin
                int kind;
                nprob++;
                kind = (nprob > 12) ? 0 : $urandom_range(0, 9);
                present_random(ans);
                if (kind <= 5) begin
                    ticks($urandom_range(0, TL - 2));
                    if ($urandom_range(0, 1) == 1) step($urandom_range(1, 3));
                    answer(ans, ans);
                end else if (kind <= 7) begin
                    answer(ans + 8'($urandom_range(1, 255)), ans);
                end else if (kind == 8) begin
                    timeout();
                end else begin
                    simultaneous(ans);
                end
            end
            check("rand_session_done", 32'(model_disarmed), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
